// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the scratch-memory arbiter.
package mem_arb_pkg;

    localparam int MEM_AW = 5;
    localparam int MEM_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } mem_arb_state_t;

    typedef logic [0:0] port_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester port of the scratch-memory arbiter.
interface mem_arbiter_if #(
    parameter int AW = mem_arb_pkg::MEM_AW,
    parameter int DW = mem_arb_pkg::MEM_DW
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, ack, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, ack, rdata);
endinterface

// File: rtl/mem_rr_arb.sv
// 2-way round-robin arbiter, one-hot grant.
// Latency: combinational grant; pointer updates on the granting edge.
// Backpressure: no grant while en is low; losers simply stay pending.
module mem_rr_arb
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    port_id_t last_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (last_q == 1'b1) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Starts at 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_q <= gnt[1];
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises two requesters onto the async scratch mem with setup/strobe/hold.
// Latency: gnt in cycle N, ack and rdata in N+3, next grant possible at N+4.
// Backpressure: requester holds req until gnt; no grant outside IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  p0,
    mem_arbiter_if.slave  p1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    inout  wire  [DW-1:0] mem_data
);
    mem_arb_state_t state_q, state_d;
    logic [1:0]     gnt;
    logic           rd_d, wr_d;
    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    port_id_t       port_q;
    logic           we_q;
    logic           data_oe;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [DW-1:0]  rdata0_q, rdata1_q;

    // Gated by rst_n so no grant is visible while reset is held.
    mem_rr_arb u_rr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rst_n && (state_q == IDLE)),
        .req   ({p1.req, p0.req}),
        .gnt   (gnt)
    );

    assign sel_we    = gnt[1] ? p1.we    : p0.we;
    assign sel_addr  = gnt[1] ? p1.addr  : p0.addr;
    assign sel_wdata = gnt[1] ? p1.wdata : p0.wdata;

    always_comb begin
        state_d = state_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        unique case (state_q)
            IDLE:   if (gnt != 2'b00) state_d = SETUP;
            SETUP: begin
                state_d = STROBE;
                rd_d    = !we_q;
                wr_d    = we_q;
            end
            STROBE: state_d = HOLD;
            HOLD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes and bus enable are flops so the async mem never sees decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            data_oe   <= 1'b0;
            port_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            mem_read  <= rd_d;
            mem_write <= wr_d;
            if (gnt != 2'b00) begin
                port_q  <= gnt[1];
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                data_oe <= sel_we;
            end else if (state_d == IDLE) begin
                data_oe <= 1'b0;
            end
            if (state_q == STROBE && !we_q) begin
                if (port_q == 1'b1) begin
                    rdata1_q <= mem_data;
                end else begin
                    rdata0_q <= mem_data;
                end
            end
        end
    end

    assign mem_addr = addr_q;
    assign mem_data = data_oe ? wdata_q : 'z;

    assign p0.gnt   = gnt[0];
    assign p1.gnt   = gnt[1];
    assign p0.ack   = (state_q == HOLD) && (port_q == 1'b0);
    assign p1.ack   = (state_q == HOLD) && (port_q == 1'b1);
    assign p0.rdata = rdata0_q;
    assign p1.rdata = rdata1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural mem, queue-driven requesters, transaction-order reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } xfer_t;

    typedef struct {
        int                port;
        logic [MEM_DW-1:0] rdata;
        logic [MEM_DW-1:0] other;
    } exp_t;

    typedef struct { int port; int cyc; } gnt_rec_t;

    typedef struct {
        int                port;
        int                cyc;
        logic [MEM_DW-1:0] rdata;
        logic [MEM_DW-1:0] other;
    } ack_rec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    wire  [MEM_DW-1:0] mem_data;
    logic [MEM_DW-1:0] mem_arr [32];

    mem_arbiter_if #(.AW(MEM_AW), .DW(MEM_DW)) p0_if ();
    mem_arbiter_if #(.AW(MEM_AW), .DW(MEM_DW)) p1_if ();

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0        (p0_if),
        .p1        (p1_if),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_data  (mem_data)
    );

    assign mem_data = mem_read ? mem_arr[mem_addr] : 'z;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int both_gnt = 0;
    int both_strobe = 0;
    int contention = 0;

    xfer_t    pend0[$];
    xfer_t    pend1[$];
    exp_t     exp_q[$];
    gnt_rec_t glog[$];
    ack_rec_t alog[$];

    logic [MEM_DW-1:0] ref_mem [32];
    logic [MEM_DW-1:0] model_rdata [2];
    int                model_last = 1;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Scratch memory: level read, write captured while the strobe is high.
    initial begin
        for (int i = 0; i < 32; i++) mem_arr[i] = '0;
        forever begin
            @(negedge clk);
            if (mem_write) mem_arr[mem_addr] = mem_data;
        end
    end

    // Requesters: keep req high while their queue holds work.
    initial begin
        p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = '0; p0_if.wdata = '0;
        p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = '0; p1_if.wdata = '0;
        forever begin
            @(posedge clk); #1;
            p0_if.req = (pend0.size() != 0);
            if (pend0.size() != 0) {p0_if.we, p0_if.addr, p0_if.wdata} = pend0[0];
            p1_if.req = (pend1.size() != 0);
            if (pend1.size() != 0) {p1_if.we, p1_if.addr, p1_if.wdata} = pend1[0];
        end
    end

    initial forever begin
        @(negedge clk);
        if (p0_if.gnt && p1_if.gnt) both_gnt++;
        if (mem_read && mem_write) both_strobe++;
        if (mem_read && dut.data_oe) contention++;
        if (p0_if.gnt) begin
            glog.push_back('{0, cyc});
            if (pend0.size() != 0) void'(pend0.pop_front());
        end
        if (p1_if.gnt) begin
            glog.push_back('{1, cyc});
            if (pend1.size() != 0) void'(pend1.pop_front());
        end
        if (p0_if.ack) alog.push_back('{0, cyc, p0_if.rdata, p1_if.rdata});
        if (p1_if.ack) alog.push_back('{1, cyc, p1_if.rdata, p0_if.rdata});
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<600000", $time);
        $fatal(1);
    end

    // Service order and results of everything queued, by the round-robin rule.
    task automatic model_run();
        xfer_t q0[$] = pend0;
        xfer_t q1[$] = pend1;
        xfer_t x;
        exp_t  e;
        int    p;
        while (q0.size() != 0 || q1.size() != 0) begin
            if (q0.size() != 0 && q1.size() != 0) p = 1 - model_last;
            else p = (q0.size() != 0) ? 0 : 1;
            model_last = p;
            x = (p == 1) ? q1.pop_front() : q0.pop_front();
            if (x.we) ref_mem[x.addr] = x.wdata;
            else model_rdata[p] = ref_mem[x.addr];
            e.port  = p;
            e.rdata = model_rdata[p];
            e.other = model_rdata[1-p];
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_logs();
        glog.delete(); alog.delete(); exp_q.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        model_last = 1;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk); #1;
            ok = (glog.size() != 0);
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound && !ok; n++) begin
            @(negedge clk); #1;
            ok = pend0.size() == 0 && pend1.size() == 0 && !p0_if.req && !p1_if.req
                 && glog.size() == alog.size();
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got=%b want=0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got=%b want=0", mem_write); end
        checks++; if (mem_addr !== 5'h00) begin errors++; $display("FAIL reset_mem_addr got=%h want=00", mem_addr); end
        checks++; if (dut.data_oe !== 1'b0) begin errors++; $display("FAIL reset_bus_release got=%b want=0", dut.data_oe); end
        checks++; if ({p1_if.gnt, p0_if.gnt, p1_if.ack, p0_if.ack} !== 4'b0) begin
            errors++; $display("FAIL reset_gnt_ack got=%b want=0000", {p1_if.gnt, p0_if.gnt, p1_if.ack, p0_if.ack}); end
        checks++; if ({p1_if.rdata, p0_if.rdata} !== 16'h0) begin
            errors++; $display("FAIL reset_rdata got=%h want=0000", {p1_if.rdata, p0_if.rdata}); end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        clear_logs();
        pend0.push_back('{1'b1, 5'h03, 8'h33});
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk); #1;
            ok = (mem_write === 1'b1);
        end
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_strobe_seen got=0 want=1"); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rstmid_write_drop got=%b want=0", mem_write); end
        checks++; if (dut.data_oe !== 1'b0) begin errors++; $display("FAIL rstmid_bus_release got=%b want=0", dut.data_oe); end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        model_last = 1;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (alog.size() != 0) begin errors++; $display("FAIL rstmid_no_ack got=%0d want=0", alog.size()); end
        checks++; if (mem_addr !== 5'h00) begin errors++; $display("FAIL rstmid_idle_addr got=%h want=00", mem_addr); end
        checks++; if ({mem_read, mem_write, p0_if.rdata} !== 10'h0) begin
            errors++; $display("FAIL rstmid_idle_out got=%h want=000", {mem_read, mem_write, p0_if.rdata}); end
    endtask

    task automatic test_write_read();
        bit ok;
        clear_logs();
        pend0.push_back('{1'b1, 5'h0A, 8'hAA});
        model_run();
        wait_gnt(ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_gnt_timeout got=0 want=1"); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            checks++; if (mem_write !== (k == 2)) begin errors++; $display("FAIL wr_strobe_N+%0d got=%b want=%b", k, mem_write, k == 2); end
            checks++; if (mem_addr !== 5'h0A) begin errors++; $display("FAIL wr_addr_N+%0d got=%h want=0a", k, mem_addr); end
            checks++; if (dut.data_oe !== (k <= 3)) begin errors++; $display("FAIL wr_drive_N+%0d got=%b want=%b", k, dut.data_oe, k <= 3); end
            if (k <= 3) begin
                checks++; if (mem_data !== 8'hAA) begin errors++; $display("FAIL wr_data_N+%0d got=%h want=aa", k, mem_data); end
            end
            checks++; if (p0_if.ack !== (k == 3)) begin errors++; $display("FAIL wr_ack_N+%0d got=%b want=%b", k, p0_if.ack, k == 3); end
        end
        wait_idle(20, ok);
        clear_logs();
        pend0.push_back('{1'b0, 5'h0A, 8'h00});
        model_run();
        wait_gnt(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rd_gnt_timeout got=0 want=1"); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            checks++; if (mem_read !== (k == 2)) begin errors++; $display("FAIL rd_strobe_N+%0d got=%b want=%b", k, mem_read, k == 2); end
            checks++; if (p0_if.ack !== (k == 3)) begin errors++; $display("FAIL rd_ack_N+%0d got=%b want=%b", k, p0_if.ack, k == 3); end
            if (k == 3) begin
                checks++; if (p0_if.rdata !== 8'hAA) begin errors++; $display("FAIL rd_data got=%h want=aa", p0_if.rdata); end
            end
        end
        wait_idle(20, ok);
    endtask

    task automatic test_tie();
        bit ok;
        apply_reset();
        clear_logs();
        pend0.push_back('{1'b1, 5'h05, 8'h55});
        pend1.push_back('{1'b0, 5'h05, 8'h00});
        model_run();
        wait_idle(40, ok);
        checks++; if (!ok || glog.size() != 2 || alog.size() != 2) begin
            errors++; $display("FAIL tie_count got=%0d/%0d want=2/2", glog.size(), alog.size());
        end else begin
            checks++; if (glog[0].port != 0 || glog[1].port != 1) begin
                errors++; $display("FAIL tie_order got=%0d,%0d want=0,1", glog[0].port, glog[1].port); end
            checks++; if (glog[1].cyc - glog[0].cyc != 4) begin
                errors++; $display("FAIL tie_spacing got=%0d want=4", glog[1].cyc - glog[0].cyc); end
            checks++; if (alog[1].port != 1 || alog[1].rdata !== 8'h55) begin
                errors++; $display("FAIL tie_p1_rdata got=%0d:%h want=1:55", alog[1].port, alog[1].rdata); end
        end
    endtask

    task automatic test_fill();
        bit ok;
        logic [7:0] blk [5];
        blk[0] = 8'h55; blk[1] = 8'hAA; blk[2] = 8'h55; blk[3] = 8'hAA; blk[4] = 8'h55;
        clear_logs();
        for (int a = 0; a < 32; a++) pend1.push_back('{1'b1, 5'(a), (a % 2 == 1) ? 8'h55 : 8'hAA});
        model_run();
        wait_idle(300, ok);
        checks++; if (!ok || alog.size() != 32) begin errors++; $display("FAIL fill_count got=%0d want=32", alog.size()); end
        clear_logs();
        for (int a = 5; a <= 9; a++) pend0.push_back('{1'b0, 5'(a), 8'h00});
        model_run();
        wait_idle(100, ok);
        checks++; if (!ok || alog.size() != 5) begin
            errors++; $display("FAIL block_count got=%0d want=5", alog.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (alog[i].rdata !== blk[i]) begin
                    errors++; $display("FAIL block_rdata[%0d] got=%h want=%h", i, alog[i].rdata, blk[i]); end
                checks++; if (alog[i].other !== model_rdata[1]) begin
                    errors++; $display("FAIL block_p1_hold[%0d] got=%h want=%h", i, alog[i].other, model_rdata[1]); end
            end
        end
    endtask

    task automatic test_alternate();
        bit ok;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            pend0.push_back('{1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom)});
            pend1.push_back('{1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom)});
        end
        model_run();
        wait_idle(60, ok);
        checks++; if (!ok || glog.size() != 6) begin
            errors++; $display("FAIL alt_count got=%0d want=6", glog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (glog[i].port != exp_q[i].port) begin
                    errors++; $display("FAIL alt_port[%0d] got=%0d want=%0d", i, glog[i].port, exp_q[i].port); end
                if (i > 0) begin
                    checks++; if (glog[i].cyc - glog[i-1].cyc != 4) begin
                        errors++; $display("FAIL alt_spacing[%0d] got=%0d want=4", i, glog[i].cyc - glog[i-1].cyc); end
                end
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int r = 0; r < 10; r++) begin
            clear_logs();
            for (int i = 0; i < int'($urandom_range(0, 4)); i++)
                pend0.push_back('{1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom)});
            for (int i = 0; i < int'($urandom_range(0, 4)); i++)
                pend1.push_back('{1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom)});
            model_run();
            wait_idle(80, ok);
            checks++; if (!ok || alog.size() != exp_q.size() || glog.size() != exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count got=%0d/%0d want=%0d", r, glog.size(), alog.size(), exp_q.size());
                continue;
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (alog[i].port != exp_q[i].port || alog[i].cyc != glog[i].cyc + 3) begin
                    errors++; $display("FAIL rand%0d_ack[%0d] got=p%0d@+%0d want=p%0d@+3", r, i,
                                       alog[i].port, alog[i].cyc - glog[i].cyc, exp_q[i].port); end
                checks++; if (alog[i].rdata !== exp_q[i].rdata || alog[i].other !== exp_q[i].other) begin
                    errors++; $display("FAIL rand%0d_rdata[%0d] got=%h/%h want=%h/%h", r, i,
                                       alog[i].rdata, alog[i].other, exp_q[i].rdata, exp_q[i].other); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        test_reset();
        test_reset_mid();
        test_write_read();
        test_tie();
        test_fill();
        test_alternate();
        test_random();
        checks++; if (both_gnt != 0) begin errors++; $display("FAIL dual_gnt got=%0d want=0", both_gnt); end
        checks++; if (both_strobe != 0) begin errors++; $display("FAIL dual_strobe got=%0d want=0", both_strobe); end
        checks++; if (contention != 0) begin errors++; $display("FAIL bus_contention got=%0d want=0", contention); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
